// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue (circular buffer, flushable)
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.

`ifndef BRANCH_PRED_M
`define BRANCH_PRED_M 8
`endif

module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int HIST_W = `BRANCH_PRED_M
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_inst,
  input  logic [31:0]              enq_pc,
  input  logic [31:0]              enq_pc_next,
  input  logic [63:0]              enq_order,
  input  logic [HIST_W-1:0]        enq_br_hist,
  output logic                     full,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_inst,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_pc_next,
  output logic [63:0]              deq_order,
  output logic [HIST_W-1:0]        deq_br_hist,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        head;
  logic [AW:0]        tail;
  logic [31:0]        mem_inst    [DEPTH];
  logic [31:0]        mem_pc      [DEPTH];
  logic [31:0]        mem_pc_next [DEPTH];
  logic [63:0]        mem_order   [DEPTH];
  logic [HIST_W-1:0]  mem_hist    [DEPTH];

  logic empty;
  logic bypass;
  logic enq_fire;
  logic deq_fire;

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign count = tail - head;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enq_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes this cycle never lands in storage.
  assign enq_fire = enq_valid && !full && !flush && !(bypass && deq_ready);
  assign deq_fire = !empty && deq_ready && !flush;

  assign deq_valid   = !empty || bypass;
  assign deq_inst    = bypass ? enq_inst    : mem_inst[head[AW-1:0]];
  assign deq_pc      = bypass ? enq_pc      : mem_pc[head[AW-1:0]];
  assign deq_pc_next = bypass ? enq_pc_next : mem_pc_next[head[AW-1:0]];
  assign deq_order   = bypass ? enq_order   : mem_order[head[AW-1:0]];
  assign deq_br_hist = bypass ? enq_br_hist : mem_hist[head[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= tail;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      mem_inst[tail[AW-1:0]]    <= enq_inst;
      mem_pc[tail[AW-1:0]]      <= enq_pc;
      mem_pc_next[tail[AW-1:0]] <= enq_pc_next;
      mem_order[tail[AW-1:0]]   <= enq_order;
      mem_hist[tail[AW-1:0]]    <= enq_br_hist;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-002 SHALL provide parameter HIST_W, default BRANCH_PRED_M, global-history width carried per entry.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  branch mispredict; discard all entries.
REQ-006 SHALL have port enq_valid  input  1  fetch presents an instruction this cycle.
REQ-007 SHALL have port enq_inst  input  32  instruction word.
REQ-008 SHALL have port enq_pc  input  32  instruction PC.
REQ-009 SHALL have port enq_pc_next  input  32  predicted next PC.
REQ-010 SHALL have port enq_order  input  64  RVFI order tag.
REQ-011 SHALL have port enq_br_hist  input  HIST_W  history snapshot at fetch.
REQ-012 SHALL have port full  output  1  queue holds DEPTH entries; drives fetch's is_fetch_q_full.
REQ-013 SHALL have port deq_ready  input  1  decode accepts head entry.
REQ-014 SHALL have port deq_valid  output  1  head entry valid.
REQ-015 SHALL have ports deq_inst 32, deq_pc 32, deq_pc_next 32, deq_order 64, deq_br_hist HIST_W  output  head-entry fields.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL store entries in a circular buffer indexed by head/tail pointers of $clog2(DEPTH) bits plus one wrap bit each.
REQ-018 SHALL assert full iff head and tail index bits are equal and wrap bits differ; empty iff both are equal; full is a function of registered state only.
REQ-019 SHALL accept an enqueue iff enq_valid && !full && !flush; the entry is written at tail and tail advances by 1, wrapping at DEPTH.
REQ-020 SHALL silently drop enq_valid while full, including when a dequeue fires in the same cycle (no push-through).
REQ-021 SHALL drive deq_valid = !empty and deq_* fields from the head entry combinationally from registered state.
REQ-022 SHALL dequeue iff deq_valid && deq_ready && !flush; head advances by 1, wrapping at DEPTH.
REQ-023 SHALL keep count unchanged on a simultaneous accepted enqueue and dequeue; count = tail - head (wrap-aware).
REQ-024 SHALL give minimum enqueue-to-deq_valid latency of 1 cycle (entry written at edge N is visible after edge N).
REQ-025 SHALL give flush priority over enqueue and dequeue: after the flush edge head = tail, count = 0, deq_valid = 0, full = 0; flush on an empty queue is a no-op.
REQ-026 SHALL preserve FIFO order of enq_order values exactly; no reordering or duplication.
REQ-027 SHALL hold deq_* stable while deq_valid && !deq_ready && !flush.

Reset
REQ-028 SHALL on rst set head = 0, tail = 0, count = 0, full = 0, deq_valid = 0; rst has priority over flush, enq and deq.
REQ-029 SHALL not reset entry storage; deq_* fields are don't-care while deq_valid = 0.
REQ-030 SHALL discard any in-flight enqueue presented in the reset cycle.

Configuration
REQ-031 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-032 With FETCH_QUEUE_BYPASS_EN defined: when empty && enq_valid && !flush, deq_valid = 1 same cycle and deq_* = enq_*; if deq_ready, the entry is consumed and not written; otherwise it is written normally.
REQ-033 Without FETCH_QUEUE_BYPASS_EN: no combinational path from enq_* to deq_*; latency per REQ-024.

Verification
REQ-034 Fill: DEPTH=8, deq_ready=0, 8 enqueues pc 0x1eceb000..+0x1c -> full=1, count=8 after 8th edge; 9th enq (pc 0x1eceb020) dropped.
REQ-035 Drain order: after REQ-034, deq_ready=1 for 8 cycles -> deq_pc 0x1eceb000,+4,...,+0x1c in order; then deq_valid=0, count=0.
REQ-036 Wrap: continuous enq+deq for 20 cycles from count=3 -> count stays 3, deq_order strictly increments by 1, pointers wrap without loss.
REQ-037 Flush collision: count=5, assert flush with enq_valid=1, deq_ready=1 -> next cycle count=0, deq_valid=0; enqueued word absent.
REQ-038 Full+deq: full=1, enq_valid=1, deq_ready=1 -> head dequeued, enqueue dropped, count=7, full=0.
REQ-039 Bypass (macro defined): empty, enq_valid=1 pc 0x1eceb100, deq_ready=1 -> deq_valid=1, deq_pc=0x1eceb100 same cycle, count stays 0; macro undefined -> deq_valid=0 that cycle, 1 next.
